// File: rtl/mux_arb_pkg.sv
// Shared definitions for the mux_read_arbiter slice.
//   SEL_W    : width of the shared selector's select input (64 sources)
//   NREQ_DEF : default number of requesters
//   state_e  : read-sequencer FSM states
package mux_arb_pkg;

    localparam int SEL_W    = 6;
    localparam int NREQ_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter core (purely combinational).
// The search starts at requester index ptr and wraps from NREQ-1 to 0.
// The first requester found wins.
//
// Ports:
//   req     : request vector, one bit per requester
//   ptr     : index where the search starts
//   gnt     : one-hot grant vector (all zero when nothing is requested)
//   gnt_idx : binary index of the winner (0 when nothing is requested)
//   gnt_any : at least one request is present
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            gnt_any
);

    int idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!gnt_any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = IDW'(idx);
                gnt_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_read_arbiter.sv
// Shares a single 64:1 data selector among NREQ requesters.
// A granted requester's source index is driven onto mux_s. The selector
// output is captured one cycle later and returned with the requester's id.
//
// Handshakes:
//   req_valid/req_ready : req_ready[w] is a single-cycle, one-hot pulse in the
//       cycle the request of requester w is accepted. req_sel[w] is sampled
//       only in that cycle. A requester may drop req_valid before it is granted,
//       and the request is then forgotten.
//   resp_valid/resp_ready : a response transfers in a cycle where both are 1.
//       While resp_valid=1 and resp_ready=0, resp_data and resp_id are held.
//
// Ports:
//   clk        : clock, all state updates on the rising edge
//   reset      : asynchronous active-low reset
//   req_valid  : per-requester read request
//   req_sel    : per-requester 6-bit source index, requester i at [i*6 +: 6]
//   req_ready  : one-hot grant pulse
//   mux_s      : select to the shared selector, changes only on a grant
//   mux_y      : selector output
//   resp_valid : response valid
//   resp_ready : response consumer accepts
//   resp_data  : captured selector data
//   resp_id    : requester owning resp_data
//   req_lock   : per-requester lock request (only with MUX_ARB_LOCK_EN)
//   state_dbg  : current FSM state (IDLE=0, READ=1, RESP=2)
//
// Optional feature macro: MUX_ARB_LOCK_EN. When it is defined, a granted
// requester that asserts req_lock keeps ownership of the selector. It wins
// the next arbitration whenever it is still requesting.
module mux_read_arbiter
    import mux_arb_pkg::*;
#(
    parameter int SIZE = 64,
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*SEL_W-1:0] req_sel,
    output logic [NREQ-1:0]       req_ready,
    output logic [SEL_W-1:0]      mux_s,
    input  logic [SIZE-1:0]       mux_y,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [SIZE-1:0]       resp_data,
    output logic [IDW-1:0]        resp_id,
`ifdef MUX_ARB_LOCK_EN
    input  logic [NREQ-1:0]       req_lock,
`endif
    output logic [1:0]            state_dbg
);

    state_e            state_q, state_d;
    logic [IDW-1:0]    p_q, p_d;
    logic [SEL_W-1:0]  mux_s_q, mux_s_d;
    logic [IDW-1:0]    resp_id_q, resp_id_d;
    logic [SIZE-1:0]   resp_data_q, resp_data_d;
    logic              resp_valid_q, resp_valid_d;

    logic [NREQ-1:0]   rr_gnt;
    logic [IDW-1:0]    rr_idx;
    logic              any_req;
    logic              lock_hit;
    logic [IDW-1:0]    win;
    logic [NREQ-1:0]   win_oh;
    logic              grant_en;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req     (req_valid),
        .ptr     (p_q),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx),
        .gnt_any (any_req)
    );

`ifdef MUX_ARB_LOCK_EN
    logic           lock_q, lock_d;
    logic [IDW-1:0] lock_id_q, lock_id_d;

    // The lock owner is preferred only while it is still requesting.
    // Otherwise, normal round-robin decides.
    assign lock_hit = lock_q && req_valid[lock_id_q];

    always_comb begin
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        if (grant_en) begin
            lock_d    = req_lock[win];
            lock_id_d = win;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_q    <= 1'b0;
            lock_id_q <= '0;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
        end
    end

    assign win    = lock_hit ? lock_id_q : rr_idx;
    assign win_oh = lock_hit ? ({{(NREQ-1){1'b0}}, 1'b1} << lock_id_q) : rr_gnt;
`else
    assign lock_hit = 1'b0;
    assign win      = rr_idx;
    assign win_oh   = rr_gnt;
`endif

    always_comb begin
        state_d      = state_q;
        p_d          = p_q;
        mux_s_d      = mux_s_q;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        resp_valid_d = resp_valid_q;
        grant_en     = 1'b0;

        case (state_q)
            IDLE: begin
                grant_en = any_req;
            end
            READ: begin
                resp_data_d  = mux_y;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                    // The same cycle can accept the next request. This gives
                    // back-to-back reads at one read every two cycles.
                    grant_en     = any_req;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // While reset is low, no grant is allowed, even though the FSM is
        // already in IDLE.
        if (!reset) begin
            grant_en = 1'b0;
        end

        if (grant_en) begin
            state_d   = READ;
            mux_s_d   = req_sel[int'(win)*SEL_W +: SEL_W];
            resp_id_d = win;
            // A grant made because of a held lock leaves the rotation
            // where it was.
            if (!lock_hit) begin
                p_d = (win == IDW'(NREQ-1)) ? '0 : win + IDW'(1);
            end
        end

        req_ready = grant_en ? win_oh : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            p_q          <= '0;
            mux_s_q      <= '0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            p_q          <= p_d;
            mux_s_q      <= mux_s_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign mux_s      = mux_s_q;
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
    assign resp_valid = resp_valid_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_mux_read_arbiter.sv
// Directed testbench for mux_read_arbiter. The shared selector is modelled as
// mux_y = mux_s, so the value of each source equals its index.
module tb_mux_read_arbiter;

    localparam int SIZE = 64;
    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*6-1:0] req_sel;
    logic [NREQ-1:0]   req_ready;
    logic [5:0]        mux_s;
    logic [SIZE-1:0]   mux_y;
    logic              resp_valid;
    logic              resp_ready;
    logic [SIZE-1:0]   resp_data;
    logic [1:0]        resp_id;
    logic [1:0]        state_dbg;
`ifdef MUX_ARB_LOCK_EN
    logic [NREQ-1:0]   req_lock;
`endif

    int checks   = 0;
    int failures = 0;

    // Clock and selector model
    always #5 clk = ~clk;
    assign mux_y = {{(SIZE-6){1'b0}}, mux_s};

    mux_read_arbiter #(.SIZE(SIZE), .NREQ(NREQ)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_sel    (req_sel),
        .req_ready  (req_ready),
        .mux_s      (mux_s),
        .mux_y      (mux_y),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
`ifdef MUX_ARB_LOCK_EN
        .req_lock   (req_lock),
`endif
        .state_dbg  (state_dbg)
    );

    // Driver tasks
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid  = '0;
        req_sel    = '0;
        resp_ready = 1'b0;
`ifdef MUX_ARB_LOCK_EN
        req_lock   = '0;
`endif
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic set_sel(input int i, input logic [5:0] v);
        req_sel[i*6 +: 6] = v;
    endtask

    task automatic drain();
        req_valid  = '0;
        resp_ready = 1'b1;
        repeat (4) next_cycle();
    endtask

    // Scenario tasks
    task automatic test_reset();
        clear_inputs();
        req_valid = 4'b1111;
        reset     = 1'b0;
        #3;
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL reset_req_ready: got %b expected 0000", req_ready);
        end
        checks++;
        if (mux_s !== 6'd0 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mux_resp: got mux_s=%0d resp_valid=%b expected 0/0", mux_s, resp_valid);
        end
        checks++;
        if (resp_data !== '0 || resp_id !== 2'd0 || state_dbg !== 2'd0) begin
            failures++;
            $display("FAIL reset_data_id_state: got data=%0h id=%0d state=%0d expected 0/0/0",
                     resp_data, resp_id, state_dbg);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        set_sel(0, 6'd17);
        req_valid  = 4'b0001;
        resp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL single_grant: got %b expected 0001", req_ready);
        end
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (mux_s !== 6'd17 || req_ready !== 4'b0000 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_read: got mux_s=%0d ready=%b rv=%b expected 17/0000/0",
                     mux_s, req_ready, resp_valid);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 64'd17 || resp_id !== 2'd0) begin
            failures++;
            $display("FAIL single_resp: got rv=%b data=%0d id=%0d expected 1/17/0",
                     resp_valid, resp_data, resp_id);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || state_dbg !== 2'd0) begin
            failures++;
            $display("FAIL single_idle: got rv=%b state=%0d expected 0/0", resp_valid, state_dbg);
        end
        drain();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                                    4'b0000, 4'b1000, 4'b0000, 4'b0001};
        logic       exp_rv  [9] = '{0, 0, 1, 0, 1, 0, 1, 0, 1};
        logic [1:0] exp_id  [9] = '{0, 0, 0, 0, 1, 0, 2, 0, 3};
        do_reset();
        for (int i = 0; i < NREQ; i++) set_sel(i, 6'(10 + i));
        req_valid  = 4'b1111;
        resp_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== exp_gnt[c] || resp_valid !== exp_rv[c]) begin
                failures++;
                $display("FAIL rr_cycle%0d: got ready=%b rv=%b expected %b/%b",
                         c, req_ready, resp_valid, exp_gnt[c], exp_rv[c]);
            end
            if (exp_rv[c]) begin
                checks++;
                if (resp_id !== exp_id[c] || resp_data !== 64'(10 + exp_id[c])) begin
                    failures++;
                    $display("FAIL rr_resp%0d: got id=%0d data=%0d expected %0d/%0d",
                             c, resp_id, resp_data, exp_id[c], 10 + exp_id[c]);
                end
            end
            next_cycle();
        end
        drain();
    endtask

    task automatic test_backpressure();
        do_reset();
        set_sel(1, 6'd33);
        req_valid  = 4'b0010;
        resp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL bp_grant: got %b expected 0010", req_ready);
        end
        next_cycle();
        // New select values after the grant must not leak into mux_s.
        req_valid = 4'b1111;
        set_sel(1, 6'd5);
        set_sel(2, 6'd44);
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000 || mux_s !== 6'd33) begin
            failures++;
            $display("FAIL bp_read: got ready=%b mux_s=%0d expected 0000/33", req_ready, mux_s);
        end
        next_cycle();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b1 || resp_data !== 64'd33 || resp_id !== 2'd1 ||
                req_ready !== 4'b0000 || mux_s !== 6'd33) begin
                failures++;
                $display("FAIL bp_hold%0d: got rv=%b data=%0d id=%0d ready=%b mux_s=%0d expected 1/33/1/0000/33",
                         k, resp_valid, resp_data, resp_id, req_ready, mux_s);
            end
            next_cycle();
        end
        resp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL bp_release_grant: got %b expected 0100", req_ready);
        end
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (mux_s !== 6'd44) begin
            failures++;
            $display("FAIL bp_next_sel: got %0d expected 44", mux_s);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 64'd44 || resp_id !== 2'd2) begin
            failures++;
            $display("FAIL bp_next_resp: got rv=%b data=%0d id=%0d expected 1/44/2",
                     resp_valid, resp_data, resp_id);
        end
        drain();
    endtask

    task automatic test_wrap();
        do_reset();
        set_sel(2, 6'd2);
        req_valid  = 4'b0100;
        resp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL wrap_setup: got %b expected 0100", req_ready);
        end
        next_cycle();
        drain();
        set_sel(3, 6'd63);
        set_sel(0, 6'd1);
        req_valid = 4'b1001;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++;
            $display("FAIL wrap_first: got %b expected 1000", req_ready);
        end
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001 || resp_id !== 2'd3 || resp_data !== 64'd63) begin
            failures++;
            $display("FAIL wrap_second: got ready=%b id=%0d data=%0d expected 0001/3/63",
                     req_ready, resp_id, resp_data);
        end
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (mux_s !== 6'd1) begin
            failures++;
            $display("FAIL wrap_sel: got %0d expected 1", mux_s);
        end
        drain();
    endtask

    task automatic test_reset_in_read();
        do_reset();
        set_sel(2, 6'd50);
        req_valid  = 4'b0100;
        resp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL rst_read_grant: got %b expected 0100", req_ready);
        end
        next_cycle();
        req_valid = 4'b1111;
        reset     = 1'b0;
        #1;
        checks++;
        if (mux_s !== 6'd0 || resp_valid !== 1'b0 || resp_data !== '0 || resp_id !== 2'd0 ||
            req_ready !== 4'b0000 || state_dbg !== 2'd0) begin
            failures++;
            $display("FAIL rst_read_clear: got mux_s=%0d rv=%b data=%0d id=%0d ready=%b state=%0d expected all 0",
                     mux_s, resp_valid, resp_data, resp_id, req_ready, state_dbg);
        end
        repeat (2) next_cycle();
        reset      = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b0) begin
                failures++;
                $display("FAIL rst_no_replay%0d: got rv=%b expected 0", k, resp_valid);
            end
            next_cycle();
        end
        req_valid = 4'b1111;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL rst_first_grant: got %b expected 0001", req_ready);
        end
        next_cycle();
        drain();
    endtask

`ifdef MUX_ARB_LOCK_EN
    task automatic test_lock();
        logic [3:0] exp_l [9] = '{4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b0100,
                                  4'b0000, 4'b0100, 4'b0000, 4'b1000};
        do_reset();
        req_valid  = 4'b0010;
        resp_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (c == 1) begin
                req_valid = 4'b1111;
                req_lock  = 4'b0100;
            end
            if (c == 5) req_lock = 4'b0000;
            @(negedge clk);
            checks++;
            if (req_ready !== exp_l[c]) begin
                failures++;
                $display("FAIL lock_cycle%0d: got %b expected %b", c, req_ready, exp_l[c]);
            end
            next_cycle();
        end
        drain();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_reset_in_read();
`ifdef MUX_ARB_LOCK_EN
        test_lock();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
